// File: rtl/alu_pkg.sv
// Shared definitions for the extended ALU: op-code encoding, flag bit positions
// and the multiplier sequencer states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_CMA = 4'd5,
    OP_RLC = 4'd6,
    OP_SRL = 4'd7,
    OP_ADC = 4'd8,
    OP_SBB = 4'd9,
    OP_INC = 4'd10,
    OP_DEC = 4'd11,
    OP_RAL = 4'd12,
    OP_RAR = 4'd13,
    OP_CMP = 4'd14,
    OP_MUL = 4'd15
  } op_e;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_P = 1;
  localparam int FLAG_C = 0;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/alu_mul.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH cycles
// per product. fin/res expose the completing edge so the parent can commit flags.
module alu_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic                 fin,
  output logic [2*WIDTH-1:0]   prod,
  output logic [2*WIDTH-1:0]   res
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_e           state_q, state_d;
  logic [2*WIDTH-1:0]   acc, mcand, acc_d;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;

  always_comb begin
    state_d = state_q;
    fin     = 1'b0;
    acc_d   = acc + (mplier[0] ? mcand : '0);
    case (state_q)
      MUL_IDLE: if (start) state_d = MUL_RUN;
      MUL_RUN: begin
        if (cnt == LAST) begin
          fin     = 1'b1;
          state_d = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= MUL_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      prod   <= '0;
      done   <= 1'b0;
    end else begin
      done <= fin;
      if (state_q == MUL_IDLE) begin
        if (start) begin
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, a};
          mplier <= b;
          cnt    <= '0;
        end
      end else begin
        acc    <= acc_d;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (fin) prod <= acc_d;
      end
    end
  end

  assign busy = (state_q == MUL_RUN);
  assign res  = acc_d;

endmodule

// File: rtl/alu_ext.sv
// Extended accumulator ALU: combinational ops 0..14 against tmp and the carry
// flag, plus a multi-cycle unsigned multiply delegated to alu_mul.
module alu_ext
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BUS_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [3:0]         op,
  input  logic               load,
  input  logic [BUS_W-1:0]   bus,
  input  logic               flag_we,
  input  logic               start,
  output logic [WIDTH-1:0]   out,
  output logic [3:0]         flags,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  op_e                opc;
  logic [WIDTH-1:0]   tmp, res, fres;
  logic [WIDTH:0]     ext;
  logic               cf, cn, upd;
  logic [3:0]         fnext, mflags;
  logic               mul_fin;
  logic [2*WIDTH-1:0] mul_res;

  assign opc = op_e'(op);
  assign cf  = flags[FLAG_C];

  generate
    if (BUS_W > WIDTH) begin : g_bus_hi
      logic unused_bus_hi;
      assign unused_bus_hi = ^bus[BUS_W-1:WIDTH];
    end
  endgenerate

  // fres is what the flags see; it differs from out only for CMP.
  always_comb begin
    ext  = '0;
    res  = '0;
    cn   = cf;
    upd  = 1'b1;
    case (opc)
      OP_ADD: begin ext = {1'b0, a} + {1'b0, tmp}; res = ext[WIDTH-1:0]; cn = ext[WIDTH]; end
      OP_SUB: begin ext = {1'b0, a} - {1'b0, tmp}; res = ext[WIDTH-1:0]; cn = ext[WIDTH]; end
      OP_AND: begin res = a & tmp; cn = 1'b0; end
      OP_OR:  begin res = a | tmp; cn = 1'b0; end
      OP_XOR: begin res = a ^ tmp; cn = 1'b0; end
      OP_CMA: begin res = ~a; upd = 1'b0; end
      OP_RLC: begin res = {a[WIDTH-2:0], a[WIDTH-1]}; cn = a[WIDTH-1]; end
      OP_SRL: begin res = {1'b0, a[WIDTH-1:1]}; cn = a[0]; end
      OP_ADC: begin
        ext = {1'b0, a} + {1'b0, tmp} + {{WIDTH{1'b0}}, cf};
        res = ext[WIDTH-1:0];
        cn  = ext[WIDTH];
      end
      OP_SBB: begin
        ext = {1'b0, a} - {1'b0, tmp} - {{WIDTH{1'b0}}, cf};
        res = ext[WIDTH-1:0];
        cn  = ext[WIDTH];
      end
      OP_INC: res = a + WIDTH'(1);
      OP_DEC: res = a - WIDTH'(1);
      OP_RAL: begin res = {a[WIDTH-2:0], cf}; cn = a[WIDTH-1]; end
      OP_RAR: begin res = {cf, a[WIDTH-1:1]}; cn = a[0]; end
      OP_CMP: begin ext = {1'b0, a} - {1'b0, tmp}; res = ext[WIDTH-1:0]; cn = ext[WIDTH]; end
      OP_MUL: begin res = prod[WIDTH-1:0]; upd = 1'b0; end
      default: upd = 1'b0;
    endcase
    fres = res;
    if (opc == OP_CMP) res = a;
  end

  always_comb begin
    fnext          = '0;
    fnext[FLAG_S]  = fres[WIDTH-1];
    fnext[FLAG_Z]  = (fres == '0);
    fnext[FLAG_P]  = ~^fres;
    fnext[FLAG_C]  = cn;
    mflags         = '0;
    mflags[FLAG_S] = mul_res[WIDTH-1];
    mflags[FLAG_Z] = (mul_res == '0);
    mflags[FLAG_P] = ~^mul_res[WIDTH-1:0];
    mflags[FLAG_C] = |mul_res[2*WIDTH-1:WIDTH];
  end

  assign out = res;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmp   <= '0;
      flags <= '0;
    end else begin
      if (load) tmp <= bus[WIDTH-1:0];
      // mul_fin only occurs while busy, so it never competes with flag_we.
      if (mul_fin)                 flags <= mflags;
      else if (flag_we && !busy && upd) flags <= fnext;
    end
  end

  alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (start && (opc == OP_MUL)),
    .a     (a),
    .b     (tmp),
    .busy  (busy),
    .done  (done),
    .fin   (mul_fin),
    .prod  (prod),
    .res   (mul_res)
  );

endmodule

// File: tb/tb_alu_ext.sv
// Self-checking bench for alu_ext (WIDTH=8): directed scenarios followed by
// random traffic, all compared against an integer-arithmetic reference model.
module tb_alu_ext;

  localparam int W  = 8;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  a = '0;
  logic [3:0]    op = '0;
  logic          load = 1'b0;
  logic [BW-1:0] bus = '0;
  logic          flag_we = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  out;
  logic [3:0]    flags;
  logic          busy, done;
  logic [2*W-1:0] prod;

  always #5 clk = ~clk;

  alu_ext #(.WIDTH(W), .BUS_W(BW)) dut (
    .clk(clk), .rst(rst), .a(a), .op(op), .load(load), .bus(bus),
    .flag_we(flag_we), .start(start), .out(out), .flags(flags),
    .busy(busy), .done(done), .prod(prod)
  );

  int checks = 0;
  int errors = 0;

  int m_tmp = 0, m_flags = 0, m_prod = 0, m_left = 0, m_ma = 0, m_mb = 0;
  int m_done = 0;

  function automatic int mk_flags(int r, int c);
    int v;
    v = r & 255;
    return ((v >= 128) ? 8 : 0) | ((v == 0) ? 4 : 0) |
           (($countones(v) % 2 == 0) ? 2 : 0) | ((c != 0) ? 1 : 0);
  endfunction

  function automatic void ref_alu(input int opv, input int av, input int tv, input int cin,
                                  output int res, output int fl, output bit upd);
    int fr, c;
    c   = cin;
    upd = 1'b1;
    case (opv)
      0:  begin fr = av + tv;         c = (fr > 255); end
      1:  begin fr = av - tv;         c = (av < tv); end
      2:  begin fr = av & tv;         c = 0; end
      3:  begin fr = av | tv;         c = 0; end
      4:  begin fr = av ^ tv;         c = 0; end
      5:  begin fr = 255 - av;        upd = 1'b0; end
      6:  begin fr = (av * 2) % 256 + av / 128; c = av / 128; end
      7:  begin fr = av / 2;          c = av % 2; end
      8:  begin fr = av + tv + cin;   c = (fr > 255); end
      9:  begin fr = av - tv - cin;   c = (av < tv + cin); end
      10: fr = av + 1;
      11: fr = av - 1;
      12: begin fr = (av * 2) % 256 + cin; c = av / 128; end
      13: begin fr = av / 2 + cin * 128;   c = av % 2; end
      14: begin fr = av - tv;         c = (av < tv); end
      default: begin fr = m_prod % 256; upd = 1'b0; end
    endcase
    fr  = fr & 255;
    res = (opv == 14) ? av : fr;
    fl  = mk_flags(fr, c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic check_outs();
    int res, fl;
    bit upd;
    ref_alu(int'(op), int'(a), m_tmp, m_flags & 1, res, fl, upd);
    chk("out",   32'(out),   32'(res));
    chk("flags", 32'(flags), 32'(m_flags));
    chk("busy",  32'(busy),  32'(m_left > 0));
    chk("done",  32'(done),  32'(m_done));
    chk("prod",  32'(prod),  32'(m_prod));
  endtask

  task automatic tick();
    int res, fl, lo;
    bit upd, was_busy;
    was_busy = (m_left > 0);
    ref_alu(int'(op), int'(a), m_tmp, m_flags & 1, res, fl, upd);
    @(posedge clk);
    #1;
    if (!rst) begin
      m_tmp = 0; m_flags = 0; m_prod = 0; m_left = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (was_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_prod  = m_ma * m_mb;
          m_done  = 1;
          lo      = m_prod % 256;
          m_flags = ((lo >= 128) ? 8 : 0) | ((m_prod == 0) ? 4 : 0) |
                    (($countones(lo) % 2 == 0) ? 2 : 0) | ((m_prod > 255) ? 1 : 0);
        end
      end else begin
        if (start && op == 4'd15) begin
          m_ma = int'(a); m_mb = m_tmp; m_left = W;
        end
        if (flag_we && upd) m_flags = fl;
      end
      if (load) m_tmp = int'(bus) & 255;
    end
    check_outs();
  endtask

  initial begin
    int nbusy, ndone;

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    chk("rst_prod",  32'(prod),  32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_done",  32'(done),  32'h0);
    rst = 1'b1;

    // ADD wrap: 0xFF + 0x01
    bus = 16'h0001; load = 1'b1; tick(); load = 1'b0;
    a = 8'hFF; op = 4'd0; #1;
    chk("add_out", 32'(out), 32'h00);
    flag_we = 1'b1; tick(); flag_we = 1'b0;
    chk("add_flags", 32'(flags), 32'b0111);

    // ADC with C=1
    bus = 16'h0020; load = 1'b1; tick(); load = 1'b0;
    a = 8'h10; op = 4'd8; #1;
    chk("adc_out", 32'(out), 32'h31);

    // SBB with C=0
    op = 4'd2; flag_we = 1'b1; tick(); flag_we = 1'b0;
    bus = 16'h0007; load = 1'b1; tick(); load = 1'b0;
    a = 8'h05; op = 4'd9; #1;
    chk("sbb_out", 32'(out), 32'hFE);
    flag_we = 1'b1; tick(); flag_we = 1'b0;
    chk("sbb_flags", 32'(flags), 32'b1001);

    // RLC, then RAL from C=0, then CMA leaves flags alone
    a = 8'h81; op = 4'd6; #1;
    chk("rlc_out", 32'(out), 32'h03);
    flag_we = 1'b1; tick(); flag_we = 1'b0;
    chk("rlc_flags", 32'(flags), 32'b0011);
    op = 4'd2; flag_we = 1'b1; tick();
    a = 8'h80; op = 4'd12; flag_we = 1'b0; #1;
    chk("ral_out", 32'(out), 32'h00);
    flag_we = 1'b1; tick(); flag_we = 1'b0;
    chk("ral_flags", 32'(flags), 32'b0111);
    a = 8'h3C; op = 4'd5; flag_we = 1'b1; tick(); flag_we = 1'b0;
    chk("cma_flags", 32'(flags), 32'b0111);

    // MUL 0xFF*0xFF with a stray start mid-run and flag_we during busy
    bus = 16'h00FF; load = 1'b1; tick(); load = 1'b0;
    a = 8'hFF; op = 4'd15; start = 1'b1; tick(); start = 1'b0;
    nbusy = busy ? 1 : 0; ndone = 0;
    for (int i = 0; i < 14; i++) begin
      start   = (i == 2);
      flag_we = (i == 4);
      a       = (i == 2) ? 8'h11 : 8'hFF;
      tick();
      if (busy) nbusy++;
      if (done) ndone++;
    end
    start = 1'b0; flag_we = 1'b0; a = 8'hFF;
    chk("mul_busy_cycles", 32'(nbusy), 32'd8);
    chk("mul_done_pulses", 32'(ndone), 32'd1);
    chk("mul_prod",  32'(prod),  32'hFE01);
    chk("mul_out",   32'(out),   32'h01);
    chk("mul_flags", 32'(flags), 32'b0001);

    // Load during busy, then relaunch on the done cycle
    a = 8'h03; start = 1'b1; tick(); start = 1'b0;
    tick();
    bus = 16'h1234; load = 1'b1; tick(); load = 1'b0;
    nbusy = 0;
    while (!done && nbusy < 20) begin tick(); nbusy++; end
    chk("mul_done_seen", 32'(done), 32'h1);
    chk("mul_load_prod", 32'(prod), 32'h02FD);
    a = 8'h02; start = 1'b1; tick(); start = 1'b0;
    chk("mul_relaunch", 32'(busy), 32'h1);
    nbusy = 0;
    while (!done && nbusy < 20) begin tick(); nbusy++; end
    chk("mul2_prod", 32'(prod), 32'h0068);
    op = 4'd3; a = 8'h00; #1;
    chk("tmp_after_load", 32'(out), 32'h34);

    // Reset on the third busy cycle; load during reset ignored
    op = 4'd15; a = 8'h07; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    rst = 1'b0; load = 1'b1; bus = 16'h0055; flag_we = 1'b1; start = 1'b1;
    tick();
    rst = 1'b1; load = 1'b0; flag_we = 1'b0; start = 1'b0;
    chk("mrst_busy",  32'(busy),  32'h0);
    chk("mrst_done",  32'(done),  32'h0);
    chk("mrst_prod",  32'(prod),  32'h0);
    chk("mrst_flags", 32'(flags), 32'h0);
    op = 4'd3; a = 8'h00; #1;
    chk("mrst_tmp", 32'(out), 32'h00);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (done) ndone++; end
    chk("mrst_no_done", 32'(ndone), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 59) != 0);
      op      = 4'($urandom_range(0, 15));
      a       = 8'($urandom);
      bus     = 16'($urandom);
      load    = ($urandom_range(0, 3) == 0);
      flag_we = ($urandom_range(0, 1) == 0);
      start   = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ext.md
ALU_EXT -- requirements
Module: alu_ext

Interface
REQ-001 Parameter WIDTH, default 8: datapath width; legal values 4..32.
REQ-002 Parameter BUS_W, default 16: bus width; must be at least WIDTH.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-low.
REQ-005 a  in  WIDTH  accumulator operand.
REQ-006 op  in  4  operation select (codes in REQ-013).
REQ-007 load  in  1  tmp register loads bus[WIDTH-1:0].
REQ-008 bus  in  BUS_W  system bus.
REQ-009 flag_we  in  1  commits the current op's flags to the flag register.
REQ-010 start  in  1  launches MUL (sampled only when op=MUL).
REQ-011 out  out  WIDTH  result; flags  out  4  {S,Z,P,C} = bits [3:0].
REQ-012 busy  out  1  multiply in progress; done  out  1  one-cycle completion pulse; prod  out  2*WIDTH  product.

Function
REQ-013 Op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMA, 6 RLC (rotate left circular), 7 SRL (logical shift right), 8 ADC, 9 SBB, 10 INC, 11 DEC, 12 RAL (rotate left through C), 13 RAR (rotate right through C), 14 CMP, 15 MUL; codes 0..7 keep the prior-generation behaviour.
REQ-014 out SHALL be combinational from a, tmp and flag C for ops 0..14, with zero latency; CMP drives out=a.
REQ-015 ADD/ADC/SUB/SBB SHALL be modulo 2^WIDTH; ADC adds C; SBB subtracts C; C = carry out (add) or borrow (sub, CMP).
REQ-016 Logic ops SHALL set C=0; INC/DEC SHALL leave C unchanged; shifts/rotates SHALL set C to the bit shifted out; CMA SHALL leave all flags unchanged.
REQ-017 Z = result==0, S = result MSB, P = even parity of result; CMP flags derive from a-tmp.
REQ-018 On flag_we=1 and busy=0, flags SHALL update at the next edge; flag_we during busy SHALL be ignored.
REQ-019 tmp SHALL load on load=1 in any state, including while busy.
REQ-020 MUL: start=1 with op=MUL and busy=0 SHALL capture a and tmp (unsigned) at that edge; busy=1 for exactly WIDTH cycles afterwards.
REQ-021 On the edge where busy falls, prod SHALL take a*tmp and done SHALL be 1 for exactly one cycle; prod holds until the next completed MUL or reset.
REQ-022 While op=MUL, out SHALL equal prod[WIDTH-1:0].
REQ-023 MUL SHALL always update flags at done: Z = prod==0, C = |prod[2W-1:W], S and P from prod[W-1:0].
REQ-024 start while busy=1, or with op!=MUL, SHALL be ignored; start coincident with done SHALL launch a new MUL.
REQ-025 Multiplier state SHALL be an FSM IDLE -> RUN (WIDTH-cycle counter) -> IDLE; done asserts on the RUN->IDLE transition.

Reset
REQ-026 rst=0 at a rising edge SHALL clear tmp, flags, prod, counter, busy and done, and return the FSM to IDLE, including mid-multiply; out then follows REQ-014 with tmp=0.
REQ-027 load, start and flag_we SHALL have no effect in any cycle where rst=0.

Structure
REQ-028 Package alu_pkg SHALL hold op-code constants and flag bit indices (FLAG_S=3, FLAG_Z=2, FLAG_P=1, FLAG_C=0).
REQ-029 The multiplier SHALL be a sub-module alu_mul (shift-add, one partial product per cycle, WIDTH-parametrised) owning busy, done and prod.

Verification (WIDTH=8)
REQ-030 tmp=0x01, a=0xFF, ADD, flag_we -> out=0x00; flags Z=1, C=1, S=0, P=1.
REQ-031 C=1, tmp=0x20, a=0x10, ADC -> out=0x31; SBB with a=0x05, tmp=0x07, C=0 -> out=0xFE, C=1, S=1.
REQ-032 a=0x81, RLC -> out=0x03, C=1; a=0x80, C=0, RAL -> out=0x00, C=1; CMA with flag_we -> flags unchanged.
REQ-033 a=0xFF, tmp=0xFF, MUL start -> busy high 8 cycles, single done pulse, prod=0xFE01, out=0x01, C=1, Z=0; extra start during busy ignored.
REQ-034 rst=0 on the 3rd busy cycle -> next edge: busy=0, done=0, prod=0, flags=0, tmp=0; no done pulse follows.
REQ-035 load with bus=0x1234 during busy -> tmp=0x34; in-flight product is unaffected.
